// File: rtl/key_pkg.sv
// Shared types and default timing constants for the pushbutton debouncer.
package key_pkg;

   typedef enum logic [1:0] {
      RELEASED    = 2'd0,
      PRESS_CHK   = 2'd1,
      PRESSED     = 2'd2,
      RELEASE_CHK = 2'd3
   } key_state_t;

   localparam int CLK_HZ              = 50_000_000;
   localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
   localparam int HOLD_CYCLES_DEF     = CLK_HZ;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One debounced key: synchroniser, press/release qualification FSM and hold timer.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic srst,
   input  logic key_raw,
   output logic key_pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic hold_pulse
);

   localparam int CNT_W  = cnt_width(DEBOUNCE_CYCLES);
   localparam int HOLD_W = cnt_width(HOLD_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic              stage1_r;
   logic              stage2_r;
   logic              sync_pressed_s;
   key_state_t        state_r;
   key_state_t        state_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic [HOLD_W-1:0] hold_cnt_r;
   logic [HOLD_W-1:0] hold_cnt_nxt_s;
   logic              hold_done_r;
   logic              hold_done_nxt_s;
   logic              hold_fire_s;
   logic              key_pressed_r;
   logic              press_pulse_r;
   logic              release_pulse_r;
   logic              hold_pulse_r;
   logic              key_pressed_nxt_s;
   logic              press_pulse_nxt_s;
   logic              release_pulse_nxt_s;
   logic              hold_pulse_nxt_s;

   // Two-flop synchroniser, idling at 1 so a reset always restarts from released
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         stage1_r <= 1'b1;
         stage2_r <= 1'b1;
      end else if (srst) begin
         stage1_r <= 1'b1;
         stage2_r <= 1'b1;
      end else begin
         stage1_r <= key_raw;
         stage2_r <= stage1_r;
      end
   end

   assign sync_pressed_s = ~stage2_r;

   // State register
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state_r <= RELEASED;
      end else if (srst) begin
         state_r <= RELEASED;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: a change is accepted only after an unbroken run of samples
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         RELEASED: begin
            if (sync_pressed_s) begin
               state_nxt_s = PRESS_CHK;
            end else begin
               state_nxt_s = RELEASED;
            end
         end
         PRESS_CHK: begin
            if (!sync_pressed_s) begin
               state_nxt_s = RELEASED;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = PRESSED;
            end else begin
               state_nxt_s = PRESS_CHK;
            end
         end
         PRESSED: begin
            if (!sync_pressed_s) begin
               state_nxt_s = RELEASE_CHK;
            end else begin
               state_nxt_s = PRESSED;
            end
         end
         RELEASE_CHK: begin
            if (sync_pressed_s) begin
               state_nxt_s = PRESSED;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = RELEASED;
            end else begin
               state_nxt_s = RELEASE_CHK;
            end
         end
         default: begin
            state_nxt_s = RELEASED;
         end
      endcase
   end

   // Counter updates; the hold timer only advances while steadily pressed
   always_comb begin
      cnt_nxt_s       = '0;
      hold_cnt_nxt_s  = hold_cnt_r;
      hold_done_nxt_s = hold_done_r;
      hold_fire_s     = 1'b0;
      if (((state_r == PRESS_CHK) || (state_r == RELEASE_CHK)) && (state_nxt_s == state_r)) begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
      end else begin
         cnt_nxt_s = '0;
      end
      if ((state_r == PRESS_CHK) && (state_nxt_s == PRESSED)) begin
         hold_cnt_nxt_s  = '0;
         hold_done_nxt_s = 1'b0;
      end else if ((state_r == PRESSED) && sync_pressed_s) begin
         if (hold_cnt_r < HOLD_LAST) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_W'(1);
         end else if (!hold_done_r) begin
            hold_fire_s     = 1'b1;
            hold_done_nxt_s = 1'b1;
         end else begin
            hold_cnt_nxt_s  = hold_cnt_r;
            hold_done_nxt_s = hold_done_r;
         end
      end else begin
         hold_cnt_nxt_s  = hold_cnt_r;
         hold_done_nxt_s = hold_done_r;
      end
   end

   // Counter registers
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         cnt_r       <= '0;
         hold_cnt_r  <= '0;
         hold_done_r <= 1'b0;
      end else if (srst) begin
         cnt_r       <= '0;
         hold_cnt_r  <= '0;
         hold_done_r <= 1'b0;
      end else begin
         cnt_r       <= cnt_nxt_s;
         hold_cnt_r  <= hold_cnt_nxt_s;
         hold_done_r <= hold_done_nxt_s;
      end
   end

   // Output decode from the transition being taken this cycle
   always_comb begin
      key_pressed_nxt_s   = (state_nxt_s == PRESSED) || (state_nxt_s == RELEASE_CHK);
      press_pulse_nxt_s   = (state_r == PRESS_CHK) && (state_nxt_s == PRESSED);
      release_pulse_nxt_s = (state_r == RELEASE_CHK) && (state_nxt_s == RELEASED);
      hold_pulse_nxt_s    = hold_fire_s;
   end

   // Registered outputs
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_pressed_r   <= 1'b0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         hold_pulse_r    <= 1'b0;
      end else if (srst) begin
         key_pressed_r   <= 1'b0;
         press_pulse_r   <= 1'b0;
         release_pulse_r <= 1'b0;
         hold_pulse_r    <= 1'b0;
      end else begin
         key_pressed_r   <= key_pressed_nxt_s;
         press_pulse_r   <= press_pulse_nxt_s;
         release_pulse_r <= release_pulse_nxt_s;
         hold_pulse_r    <= hold_pulse_nxt_s;
      end
   end

   assign key_pressed   = key_pressed_r;
   assign press_pulse   = press_pulse_r;
   assign release_pulse = release_pulse_r;
   assign hold_pulse    = hold_pulse_r;

endmodule

// File: rtl/key_debounce.sv
// Debounces CHANNELS raw active-low pushbuttons into clean levels and event pulses.
module key_debounce
   import key_pkg::*;
#(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF
) (
   input  logic                CLOCK_50,
   input  logic                RESET_N,
   input  logic [CHANNELS-1:0] KEY,
   output logic [CHANNELS-1:0] KEY_PRESSED,
   output logic [CHANNELS-1:0] PRESS_PULSE,
   output logic [CHANNELS-1:0] RELEASE_PULSE,
   output logic [CHANNELS-1:0] HOLD_PULSE
);

   // No soft-reset source exists at this level; channels only see the pin reset
   logic srst_s;
   assign srst_s = 1'b0;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES)
      ) u_ch (
         .CLOCK_50      (CLOCK_50),
         .RESET_N       (RESET_N),
         .srst          (srst_s),
         .key_raw       (KEY[i]),
         .key_pressed   (KEY_PRESSED[i]),
         .press_pulse   (PRESS_PULSE[i]),
         .release_pulse (RELEASE_PULSE[i]),
         .hold_pulse    (HOLD_PULSE[i])
      );
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input-side counterpart to the board's LED-blink counter logic: takes the raw active-low pushbuttons `KEY` on the 50 MHz board clock, synchronises them and debounces each one independently. It produces clean pressed levels plus single-cycle press, release and long-hold pulses. Downstream user logic such as LED controllers and mode selectors consumes these pulses instead of raw pins.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent keys.
- `DEBOUNCE_CYCLES`, 1_000_000: stable-sample count required to accept a change (20 ms at 50 MHz). Must be at least 2.
- `HOLD_CYCLES`, 50_000_000: cycles in `PRESSED` before the hold pulse fires (1 s).

Ports (one clock; reset is asynchronous and active-low):
- `CLOCK_50` input 1: the only clock, rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `KEY` input `CHANNELS`: raw buttons, active-low, asynchronous to `CLOCK_50`.
- `KEY_PRESSED` output `CHANNELS`: debounced level, 1 = pressed.
- `PRESS_PULSE` output `CHANNELS`: one-cycle pulse when a press is accepted.
- `RELEASE_PULSE` output `CHANNELS`: one-cycle pulse when a release is accepted.
- `HOLD_PULSE` output `CHANNELS`: one-cycle pulse, at most once per press, after `HOLD_CYCLES` continuously pressed.

## Operation
- Each channel has a 2-flop synchroniser. Both flops reset to 1 (released), and `sync_pressed = ~stage2`.
- Per-channel FSM:
  - `RELEASED`: if `sync_pressed`, go to `PRESS_CHK` and set `cnt = 0`.
  - `PRESS_CHK`: if `!sync_pressed`, return to `RELEASED` (bounce discarded, no output). Else if `cnt == DEBOUNCE_CYCLES-1`, go to `PRESSED` and assert `PRESS_PULSE`. Else `cnt++`.
  - `PRESSED`: `hold_cnt++` while `hold_cnt < HOLD_CYCLES-1`. At `hold_cnt == HOLD_CYCLES-1`, assert `HOLD_PULSE` once and latch `hold_done`. If `!sync_pressed`, go to `RELEASE_CHK` and set `cnt = 0`. `hold_cnt` and `hold_done` keep their values until the next entry.
  - `RELEASE_CHK`: mirror of `PRESS_CHK`. A bounce back to pressed returns to `PRESSED` without resetting `hold_cnt` or re-arming hold. On acceptance, go to `RELEASED` and assert `RELEASE_PULSE`.
- Entry into `PRESSED` from `PRESS_CHK` clears `hold_cnt` and `hold_done`.
- `KEY_PRESSED` is 1 in `PRESSED` and `RELEASE_CHK`, 0 otherwise.
- Width rules:
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES)`.
  - `hold_cnt` width is `$clog2(HOLD_CYCLES)`, saturating (26 bits at defaults).
  - Counters never wrap.
- Channels are fully independent; simultaneous events on any channels are handled in the same cycle.

## Timing
- All outputs are registered. Reset value of every output is 0, every FSM is `RELEASED`, and all counters are 0.
- Let edge 0 be the first rising edge at which stage 1 samples `KEY[i]=0`, with the key stable afterwards:
  - `sync_pressed` goes high after edge 1.
  - `PRESS_CHK` is entered at edge 2.
  - `PRESS_PULSE` and `KEY_PRESSED` go high after edge `2+DEBOUNCE_CYCLES`.
  - `PRESS_PULSE` lasts exactly one cycle.
- `HOLD_PULSE` goes high after edge `2+DEBOUNCE_CYCLES+HOLD_CYCLES`, if the key is still pressed.
- Release latency is symmetric: `RELEASE_PULSE` goes high `2+DEBOUNCE_CYCLES` edges after the first high sample.
- Reset asserted mid-operation:
  - Immediately clears all outputs, with no pulse emitted.
  - After `RESET_N` rises, a key still held is treated as a new press with full latency, because the synchroniser restarts from released.
- `HOLD_PULSE` and `RELEASE_PULSE` never assert in the same cycle on one channel.

## Structure
- Package `key_pkg`:
  - State enum `key_state_t` with `RELEASED`, `PRESS_CHK`, `PRESSED`, `RELEASE_CHK`.
  - Default constants `CLK_HZ = 50_000_000`, `DEBOUNCE_CYCLES_DEF`, `HOLD_CYCLES_DEF`.
- Sub-module `key_debounce_ch` holds one channel: synchroniser, FSM, both counters and three pulse registers.
- Top level `key_debounce` is a generate loop of `CHANNELS` instances.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES=8`, `HOLD_CYCLES=32`.
- Clean press: `KEY[0]` low from edge 0, held 60 cycles.
  - `PRESS_PULSE[0]` is 1 for exactly one cycle after edge 10, and `KEY_PRESSED[0]` goes high then.
  - `HOLD_PULSE[0]` is one cycle after edge 42.
  - Other channels stay 0.
- Bounce: `KEY[1]` toggles every 3 cycles for 30 cycles, then stays low.
  - No pulses during bouncing.
  - Exactly one `PRESS_PULSE[1]`, 10 edges after the final low transition is sampled.
- Release bounce: with a key pressed, `KEY` goes high 5 cycles, then low, then high stably.
  - No `RELEASE_PULSE` for the 5-cycle glitch.
  - `RELEASE_PULSE` fires 10 edges after the stable high; `KEY_PRESSED` falls then.
- Simultaneous: all four keys go low on the same edge.
  - All four `PRESS_PULSE` bits are asserted in the same cycle (after edge 10).
  - One key released early yields only its own `RELEASE_PULSE`.
- Reset mid-debounce: assert `RESET_N=0` while in `PRESS_CHK` at `cnt=5`, key held.
  - Outputs are 0 immediately.
  - After reset release, `PRESS_PULSE` fires 10 edges after the first post-reset sample.
- Long hold: key held 200 cycles.
  - Exactly one `HOLD_PULSE`.
  - No second pulse; saturated `hold_cnt` does not wrap.
